// File: rtl/alu_core_pkg.sv
// Shared ALU core types, MX format constants and the scalar rounding helpers
// used by the MX broadcast engines.
package alu_core_pkg;

  localparam int SCALING_BLOCK_SIZE  = 32;
  localparam int LARGEST_FLOAT_WIDTH = 32;
  localparam int MX_SCALE_DATA_BITS  = 8;
  localparam int MXINT8_ELEMENT_BITS = 8;
  localparam int MX_BC_DEFAULT_LANES = 8;

  typedef enum logic [1:0] {
    FLOAT32  = 2'd0,
    BFLOAT16 = 2'd1,
    FLOAT16  = 2'd2,
    INT8     = 2'd3
  } t_scalar_datatype;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } t_mx_bc_state;

  // FP32 -> BF16 with round-to-nearest-even; NaNs come out as a quiet NaN.
  function automatic logic [15:0] fp32_RNE_bf16(input logic [31:0] f);
    logic [15:0] hi;
    logic        roundUp;
    hi      = f[31:16];
    roundUp = f[15] & ((|f[14:0]) | hi[0]);
    if (f[30:23] == 8'hFF && f[22:0] != 23'd0) return {f[31], 8'hFF, 7'h40};
    return hi + {15'd0, roundUp};
  endfunction

  // BF16 -> {E8M0 scale, int8 element}; the element is 1.m in 1.6 fixed point,
  // rounded to nearest even and saturated at 127. Zero/denormals give 0,
  // Inf/NaN give the NaN scale with a zero element.
  function automatic logic [15:0] bf16_RNE_int8(input logic [15:0] b);
    logic [7:0] sig;
    logic [7:0] mag;
    logic [7:0] elem;
    sig  = {1'b1, b[6:0]};
    mag  = {1'b0, sig[7:1]} + {7'd0, sig[0] & sig[1]};
    if (mag[7]) mag = 8'd127;
    elem = b[15] ? -mag : mag;
    if (b[14:7] == 8'h00) return 16'h0000;
    if (b[14:7] == 8'hFF) return 16'hFF00;
    return {b[14:7], elem};
  endfunction

endpackage

// File: rtl/mx_bc_convert.sv
// Combinational scalar-to-MXINT8 conversion: datatype mux, rounding and the
// unsupported-datatype flag. Shared by the broadcast engine variants.
module mx_bc_convert
  import alu_core_pkg::*;
(
  input  t_scalar_datatype                 i_datatype,
  input  logic [LARGEST_FLOAT_WIDTH-1:0]   i_scalar,
  output logic [MX_SCALE_DATA_BITS-1:0]    o_scale,
  output logic [MXINT8_ELEMENT_BITS-1:0]   o_element,
  output logic                             o_err
);

  logic [15:0] w_result;

  always_comb begin
    w_result = 16'h0000;
    o_err    = 1'b0;
    case (i_datatype)
      BFLOAT16: w_result = bf16_RNE_int8(i_scalar[15:0]);
      FLOAT32:  w_result = bf16_RNE_int8(fp32_RNE_bf16(i_scalar));
      default:  o_err    = 1'b1;
    endcase
  end

  assign o_scale   = w_result[15 -: MX_SCALE_DATA_BITS];
  assign o_element = w_result[MXINT8_ELEMENT_BITS-1:0];

endmodule

// File: rtl/mx_bc_stream.sv
// Scalar-to-MXINT8 broadcast engine: converts one scalar and streams a K-element
// block as K/LANES beats. Optional MX_BC_STREAM_REPEAT_EN repeats each block.
module mx_bc_stream
  import alu_core_pkg::*;
#(
  parameter  int K     = SCALING_BLOCK_SIZE,
  parameter  int LANES = MX_BC_DEFAULT_LANES,
  localparam int BEATS = K / LANES,
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 flush,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  t_scalar_datatype                     in_datatype,
  input  logic [LARGEST_FLOAT_WIDTH-1:0]       in_scalar,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [MX_SCALE_DATA_BITS-1:0]        out_scale,
  output logic [LANES*MXINT8_ELEMENT_BITS-1:0] out_data,
  output logic [BW-1:0]                        out_beat,
  output logic                                 out_first,
  output logic                                 out_last,
  output logic                                 out_err
`ifdef MX_BC_STREAM_REPEAT_EN
  ,
  input  logic [7:0]                           in_repeat,
  output logic                                 out_block_last
`endif
);

  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  if ((K % LANES) != 0) begin : g_cfgCheck
    $error("mx_bc_stream: K must be a multiple of LANES");
  end

  t_mx_bc_state                   r_state;
  t_mx_bc_state                   w_nextState;
  logic [BW-1:0]                  r_beat;
  logic [MX_SCALE_DATA_BITS-1:0]  r_scale;
  logic [MXINT8_ELEMENT_BITS-1:0] r_elem;
  logic                           r_err;
  logic [MX_SCALE_DATA_BITS-1:0]  w_scale;
  logic [MXINT8_ELEMENT_BITS-1:0] w_elem;
  logic                           w_err;
  logic                           w_accept;
  logic                           w_beatDone;
  logic                           w_blockDone;

  mx_bc_convert u_convert (
    .i_datatype (in_datatype),
    .i_scalar   (in_scalar),
    .o_scale    (w_scale),
    .o_element  (w_elem),
    .o_err      (w_err)
  );

  assign out_valid  = (r_state == STREAM);
  assign out_scale  = r_scale;
  assign out_data   = {LANES{r_elem}};
  assign out_beat   = r_beat;
  assign out_err    = r_err;
  assign out_first  = (r_beat == '0);
  assign out_last   = (r_beat == LAST_BEAT);
  assign w_beatDone = out_valid & out_ready;
  assign w_accept   = in_valid & in_ready;

`ifdef MX_BC_STREAM_REPEAT_EN
  logic [8:0] r_repCnt;
  assign out_block_last = out_last & (r_repCnt == 9'd0);
  assign w_blockDone    = w_beatDone & out_block_last;
`else
  assign w_blockDone    = w_beatDone & out_last;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // A new scalar taken on the final beat keeps us in STREAM with no bubble.
  always_comb begin
    w_nextState = r_state;
    if (flush) begin
      w_nextState = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_nextState = STREAM;
        STREAM:  if (w_blockDone && !w_accept) w_nextState = IDLE;
        default: w_nextState = IDLE;
      endcase
    end
  end

  // in_ready is combinational from out_ready on the final beat.
  always_comb begin
    in_ready = 1'b0;
    case (r_state)
      IDLE:    in_ready = !flush;
      STREAM:  in_ready = w_blockDone & !flush;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat   <= '0;
      r_scale  <= '0;
      r_elem   <= '0;
      r_err    <= 1'b0;
`ifdef MX_BC_STREAM_REPEAT_EN
      r_repCnt <= 9'd0;
`endif
    end else if (flush) begin
      r_beat <= '0;
    end else if (w_accept) begin
      r_beat   <= '0;
      r_scale  <= w_scale;
      r_elem   <= w_elem;
      r_err    <= w_err;
`ifdef MX_BC_STREAM_REPEAT_EN
      r_repCnt <= {1'b0, in_repeat};
`endif
    end else if (w_beatDone) begin
      if (out_last) begin
        r_beat <= '0;
`ifdef MX_BC_STREAM_REPEAT_EN
        if (r_repCnt != 9'd0) r_repCnt <= r_repCnt - 9'd1;
`endif
      end else begin
        r_beat <= r_beat + 1'b1;
      end
    end
  end

endmodule
